alu_rf_pipe: RTL and testbench

ALU_RF_PIPE -- requirements
Module: alu_rf_pipe

---
 rtl/alu_rf_pkg.sv | 24 ++
 rtl/alu_rf_regfile.sv | 36 +++
 rtl/alu_rf_pipe.sv | 147 ++++++++++++++
 tb/tb_alu_rf_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rf_pkg.sv
// Shared encodings and default sizes for the alu_rf_pipe register-file ALU pipeline.
package alu_rf_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 32;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_FUNC = 2'b10,
        ALU_RSVD = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        FN_ADD = 4'b0000,
        FN_SUB = 4'b0010,
        FN_AND = 4'b0100,
        FN_OR  = 4'b0101,
        FN_XOR = 4'b0110,
        FN_NOR = 4'b0111,
        FN_SLT = 4'b1010
    } func_e;

endpackage

// File: rtl/alu_rf_regfile.sv
// Register file: two asynchronous read ports, one write port, optional hardwired-zero r0.
module alu_rf_regfile
    import alu_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && !(ZERO_REG && waddr == '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rd_data_a = (ZERO_REG && rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (ZERO_REG && rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/alu_rf_pipe.sv
// Two-stage register-file ALU pipeline (S1 operands, S2 result) with handshakes on both ends.
// Define ALU_RF_BYPASS_EN to forward same-cycle register writes to the read ports instead of stalling.
module alu_rf_pipe
    import alu_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wb_en,
    input  logic [1:0]        alu_op,
    input  logic [3:0]        func,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic [ADDR_W-1:0] out_rd
);

    logic              run;
    logic              s1_valid, s1_wb, s2_valid;
    logic [DATA_W-1:0] s1_a, s1_b;
    alu_op_e           s1_op;
    logic [3:0]        s1_func;
    logic [ADDR_W-1:0] s1_rd;
    logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b, alu_y;
    logic              rf_we, advance, accept, hazard;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // An external write owns the single write port, so a writing op in S1 waits a cycle.
    assign advance  = s1_valid && (!s2_valid || out_ready) && !(wr_en && s1_wb);
    assign in_ready = run && (!s1_valid || advance) && !hazard;
    assign accept   = in_valid && in_ready;

    assign rf_we    = wr_en || (advance && s1_wb);
    assign rf_waddr = wr_en ? wr_addr : s1_rd;
    assign rf_wdata = wr_en ? wr_data : alu_y;

    alu_rf_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rs1),
        .rd_data_a (rf_a),
        .rd_addr_b (rs2),
        .rd_data_b (rf_b),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata)
    );

`ifdef ALU_RF_BYPASS_EN
    always_comb begin
        op_a = rf_a;
        op_b = rf_b;
        if (rf_we && rf_waddr == rs1 && !(ZERO_REG && rs1 == '0)) op_a = rf_wdata;
        if (rf_we && rf_waddr == rs2 && !(ZERO_REG && rs2 == '0)) op_b = rf_wdata;
    end
    assign hazard = 1'b0;
`else
    assign op_a   = rf_a;
    assign op_b   = rf_b;
    assign hazard = advance && s1_wb && (rs1 == s1_rd || rs2 == s1_rd);
`endif

    always_comb begin
        alu_y = '0;
        case (s1_op)
            ALU_ADD: alu_y = s1_a + s1_b;
            ALU_SUB: alu_y = s1_a - s1_b;
            ALU_FUNC: begin
                case (s1_func)
                    FN_ADD:  alu_y = s1_a + s1_b;
                    FN_SUB:  alu_y = s1_a - s1_b;
                    FN_AND:  alu_y = s1_a & s1_b;
                    FN_OR:   alu_y = s1_a | s1_b;
                    FN_XOR:  alu_y = s1_a ^ s1_b;
                    FN_NOR:  alu_y = ~(s1_a | s1_b);
                    FN_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
                    default: alu_y = '0;
                endcase
            end
            default: alu_y = '0;
        endcase
    end

    // run holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            s1_valid <= 1'b0;
            s1_wb    <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= ALU_ADD;
            s1_func  <= '0;
            s1_rd    <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                s1_valid <= 1'b1;
                s1_wb    <= wb_en;
                s1_a     <= op_a;
                s1_b     <= op_b;
                s1_op    <= alu_op_e'(alu_op);
                s1_func  <= func;
                s1_rd    <= rd;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            out_rd   <= '0;
        end else if (advance) begin
            s2_valid <= 1'b1;
            result   <= alu_y;
            zero     <= (alu_y == '0);
            out_rd   <= s1_rd;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_alu_rf_pipe.sv
// Scoreboard bench for alu_rf_pipe: directed cases plus random traffic against an architectural model.
// Covers either build; expectations follow ALU_RF_BYPASS_EN when it is defined.
module tb_alu_rf_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        wb_en = 1'b0;
    logic [1:0]  alu_op = '0;
    logic [3:0]  func = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  out_rd;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [4:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m [32];
    logic [3:0]  fn_tab [7] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
    int          total = 0;
    int          bad = 0;
    bit          hold_pend = 1'b0;
    logic [31:0] h_res;
    logic [4:0]  h_rd;

    alu_rf_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .wb_en     (wb_en),
        .alu_op    (alu_op),
        .func      (func),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .out_rd    (out_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        chk(name, 32'(act), 32'(req));
    endtask

    function automatic logic [31:0] ref_alu(logic [1:0] op, logic [3:0] fn, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin
                case (fn)
                    4'd0:    return a + b;
                    4'd2:    return a - b;
                    4'd4:    return a & b;
                    4'd5:    return a | b;
                    4'd6:    return a ^ b;
                    4'd7:    return ~(a | b);
                    4'd10:   return (sa < sb) ? 32'd1 : 32'd0;
                    default: return 32'd0;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rd_model(logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef ALU_RF_BYPASS_EN
        if (wr_en && wr_addr == r) return wr_data;
`endif
        return m[r];
    endfunction

    task automatic issue_model();
        exp_t e;
        e.res = ref_alu(alu_op, func, rd_model(rs1), rd_model(rs2));
        e.z   = (e.res == 32'd0);
        e.rd  = rd;
        exp_q.push_back(e);
        if (wb_en && rd != 5'd0) m[rd] = e.res;
    endtask

    // Inputs are set just after a rising edge; decide acceptance mid-cycle, then step past the next edge.
    task automatic tick(output bit acc, output bit rdy);
        @(negedge clk);
        rdy = in_ready;
        acc = in_valid && in_ready;
        if (acc) issue_model();
        if (wr_en && wr_addr != 5'd0) m[wr_addr] = wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input bit v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                          input bit w, input logic [1:0] op, input logic [3:0] fn);
        in_valid = v; rs1 = a; rs2 = b; rd = d; wb_en = w; alu_op = op; func = fn;
    endtask

    task automatic drain();
        bit acc, rdy;
        in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick(acc, rdy);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic ext_write(input logic [4:0] a, input logic [31:0] d);
        bit acc, rdy;
        in_valid = 1'b0; wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(acc, rdy);
        wr_en = 1'b0;
    endtask

    task automatic op_const(input string name, input logic [4:0] a, input logic [4:0] b,
                            input logic [1:0] op, input logic [3:0] fn,
                            input logic [31:0] er, input logic ez);
        bit acc, rdy;
        drain();
        set_op(1'b1, a, b, 5'd0, 1'b0, op, fn);
        tick(acc, rdy);
        chk1({name, "_acc"}, acc, 1'b1);
        in_valid = 1'b0;
        chk1({name, "_lat1"}, out_valid, 1'b0);
        tick(acc, rdy);
        chk1({name, "_lat2"}, out_valid, 1'b1);
        chk(name, result, er);
        chk1({name, "_zero"}, zero, ez);
    endtask

    task automatic do_reset(input int cycles);
        bit acc, rdy;
        rst_n = 1'b0;
        in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        #1;
        for (int k = 0; k < cycles; k++) begin
            tick(acc, rdy);
            chk1("rst_in_ready", rdy, 1'b0);
        end
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'd0);
        chk1("rst_zero", zero, 1'b1);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        rst_n = 1'b1;
        tick(acc, rdy);
        chk1("rel_ready_low", rdy, 1'b0);
        tick(acc, rdy);
        chk1("rel_ready_high", rdy, 1'b1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_result", result, h_res);
                chk("hold_rd", 32'(out_rd), 32'(h_rd));
            end
            hold_pend = out_valid && !out_ready;
            h_res = result;
            h_rd  = out_rd;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected actual=result %h rd %0d required=no output", result, out_rd);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", result, e.res);
                    chk1("sb_zero", zero, e.z);
                    chk("sb_rd", 32'(out_rd), 32'(e.rd));
                end
            end
        end
    end

    initial begin : stim
        bit acc, rdy;
        int bubbles, exp_bub;
`ifdef ALU_RF_BYPASS_EN
        exp_bub = 0;
`else
        exp_bub = 1;
`endif
        do_reset(3);
        op_const("rst_regs", 5'd5, 5'd10, 2'b00, 4'd0, 32'd0, 1'b1);

        ext_write(5'd5, 32'h5555_5555);
        ext_write(5'd10, 32'hAAAA_AAAA);
        op_const("f_add", 5'd5, 5'd10, 2'b10, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        op_const("f_sub", 5'd5, 5'd10, 2'b10, 4'b0010, 32'hAAAA_AAAB, 1'b0);
        op_const("f_and", 5'd5, 5'd10, 2'b10, 4'b0100, 32'h0000_0000, 1'b1);
        op_const("f_or",  5'd5, 5'd10, 2'b10, 4'b0101, 32'hFFFF_FFFF, 1'b0);
        op_const("f_slt", 5'd5, 5'd10, 2'b10, 4'b1010, 32'h0000_0000, 1'b1);
        op_const("f_slt_neg", 5'd10, 5'd5, 2'b10, 4'b1010, 32'h0000_0001, 1'b0);
        op_const("rsvd_op", 5'd5, 5'd10, 2'b11, 4'b0000, 32'h0000_0000, 1'b1);
        op_const("undef_fn", 5'd5, 5'd10, 2'b10, 4'b0011, 32'h0000_0000, 1'b1);

        // back-to-back dependent ops
        drain();
        set_op(1'b1, 5'd5, 5'd5, 5'd3, 1'b1, 2'b00, 4'd0);
        tick(acc, rdy);
        chk1("b2b_acc_a", acc, 1'b1);
        set_op(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 2'b00, 4'd0);
        bubbles = 0;
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) begin
            tick(acc, rdy);
            if (!acc) bubbles++;
        end
        chk("b2b_bubbles", bubbles, exp_bub);
        in_valid = 1'b0;
        tick(acc, rdy);
        chk("b2b_result", result, 32'hAAAA_AAAA);

        // output backpressure with both stages full
        drain();
        out_ready = 1'b0;
        set_op(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 2'b00, 4'd0);
        tick(acc, rdy);
        chk1("bp_acc1", acc, 1'b1);
        set_op(1'b1, 5'd10, 5'd10, 5'd0, 1'b0, 2'b00, 4'd0);
        tick(acc, rdy);
        chk1("bp_acc2", acc, 1'b1);
        set_op(1'b1, 5'd5, 5'd10, 5'd0, 1'b0, 2'b01, 4'd0);
        for (int k = 0; k < 3; k++) begin
            tick(acc, rdy);
            chk1("bp_full_ready", rdy, 1'b0);
            chk1("bp_valid", out_valid, 1'b1);
            chk("bp_result", result, 32'hAAAA_AAAA);
        end
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) tick(acc, rdy);
        chk1("bp_acc3", acc, 1'b1);
        drain();

        // external write collides with a writing op leaving S1
        set_op(1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 2'b00, 4'd0);
        tick(acc, rdy);
        chk1("st_acc", acc, 1'b1);
        set_op(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 4'd0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0777;
        tick(acc, rdy);
        chk1("st_stall_ready", rdy, 1'b0);
        chk1("st_stall_valid", out_valid, 1'b0);
        wr_en = 1'b0;
        tick(acc, rdy);
        chk1("st_acc2", acc, 1'b1);
        chk1("st_valid", out_valid, 1'b1);
        chk("st_result", result, 32'h5555_5555);
        chk("st_rd", 32'(out_rd), 32'd8);
        in_valid = 1'b0;
        op_const("rd_r7", 5'd7, 5'd0, 2'b00, 4'd0, 32'h0000_0777, 1'b0);
        op_const("rd_r8", 5'd8, 5'd0, 2'b00, 4'd0, 32'h5555_5555, 1'b0);

        ext_write(5'd0, 32'h0000_1234);
        op_const("rd_r0", 5'd0, 5'd0, 2'b00, 4'd0, 32'd0, 1'b1);

        // reset with two ops in flight
        drain();
        out_ready = 1'b0;
        set_op(1'b1, 5'd5, 5'd5, 5'd11, 1'b1, 2'b00, 4'd0);
        tick(acc, rdy);
        chk1("mr_acc1", acc, 1'b1);
        set_op(1'b1, 5'd10, 5'd10, 5'd9, 1'b1, 2'b00, 4'd0);
        tick(acc, rdy);
        chk1("mr_acc2", acc, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mr_async_valid", out_valid, 1'b0);
        chk1("mr_async_ready", in_ready, 1'b0);
        do_reset(2);
        op_const("mr_r9", 5'd9, 5'd0, 2'b00, 4'd0, 32'd0, 1'b1);
        op_const("mr_r11", 5'd11, 5'd0, 2'b00, 4'd0, 32'd0, 1'b1);

        // random traffic: external writes target r16-r31 (or r0), ops write back to r0-r15
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            rd        = 5'($urandom_range(0, 15));
            wb_en     = ($urandom_range(0, 1) != 0);
            alu_op    = 2'($urandom_range(0, 3));
            func      = ($urandom_range(0, 1) != 0) ? fn_tab[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
            wr_data   = $urandom();
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc, rdy);
        end
        drain();
        for (int k = 0; k < 3; k++) tick(acc, rdy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
